modbus_tx: RTL and testbench

// Modbus RTU response transmitter; the outbound counterpart of the request receiver.

---
 rtl/modbus_tx_if.sv | 14 +
 rtl/modbus_tx.sv | 199 +++++++++++++++++++
 tb/tb_modbus_tx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/modbus_tx_if.sv
// Outbound byte stream to the UART transmitter plus the holding-register RAM read port.
interface modbus_tx_if #(
  parameter int HR_ADDR_W = 8
);
  logic [7:0]           tx_d;
  logic                 tx_v;
  logic                 tx_rdy;
  logic [HR_ADDR_W-1:0] hr_raddr;
  logic                 hr_rd;
  logic [15:0]          hr_rdata;

  modport master (output tx_d, tx_v, hr_raddr, hr_rd, input tx_rdy, hr_rdata);
  modport slave  (input tx_d, tx_v, hr_raddr, hr_rd, output tx_rdy, hr_rdata);
endinterface

// File: rtl/modbus_tx.sv
// Modbus RTU response transmitter: builds address/FC/payload/CRC-16 frames, streams them
// byte by byte to the UART, then holds the 3.5-character gap before pulsing done.
module modbus_tx #(
  parameter logic [7:0] SLAVE_ADDR    = 8'h02,
  parameter int         PRESCALER     = 100,
  parameter int         HR_ADDR_W     = 8,
  parameter int         MAX_READ_REGS = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resp_send,
  input  logic        ex_send,
  input  logic [7:0]  func_code,
  input  logic [7:0]  ex_code,
  input  logic [15:0] start_addr_r,
  input  logic [15:0] quantity_r,
  input  logic [15:0] start_addr_w,
  input  logic [15:0] quantity_w,
  modbus_tx_if.master bus,
  output logic        busy,
  output logic        done
);
  localparam int              GAP_CLKS = 35 * PRESCALER;
  localparam int              GAP_W    = $clog2(GAP_CLKS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);
  localparam logic [15:0]     MAX_Q    = 16'(MAX_READ_REGS);
  localparam logic [16:0]     HR_DEPTH = 17'(2 ** HR_ADDR_W);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_HDR, S_RD, S_RWAIT, S_DHI, S_DLO, S_CRCLO, S_CRCHI, S_GAP, S_DONE
  } state_t;

  typedef enum logic [1:0] {M_READ, M_WR1, M_WRN, M_EXC} mode_t;

  state_t               state, nstate;
  mode_t                mode_q, chk_mode;
  logic                 ex_q;
  logic [7:0]           func_q, ec_q, chk_ec;
  logic [15:0]          sar_q, qr_q, saw_q, qw_q;
  logic [2:0]           hdr_idx, hdr_last;
  logic [7:0]           nregs, reg_cnt, hdr_byte, tx_d;
  logic [15:0]          data_q, crc;
  logic [GAP_W-1:0]     gap_cnt;
  logic [HR_ADDR_W-1:0] hr_raddr;
  logic [16:0]          rd_end;
  logic                 trig, xfer, tx_v, hr_rd;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  assign trig   = resp_send | ex_send;
  assign xfer   = tx_v & bus.tx_rdy;
  assign rd_end = {1'b0, sar_q} + {1'b0, qr_q};

  // Request validation, evaluated on the latched copy of the inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    chk_mode = M_EXC;
    chk_ec   = ec_q;
    if (!ex_q) begin
      case (func_q)
        8'h03, 8'h17: begin
          if (qr_q == 16'd0 || qr_q > MAX_Q) chk_ec = 8'h03;
          else if (rd_end > HR_DEPTH)         chk_ec = 8'h02;
          else                                chk_mode = M_READ;
        end
        8'h06:   chk_mode = M_WR1;
        8'h10:   chk_mode = M_WRN;
        default: chk_ec = 8'h01;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops see pre-edge values.
    if (!rst) state <= S_IDLE;
    else      state <= nstate;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q     <= 1'b0;
      func_q   <= '0;
      ec_q     <= '0;
      sar_q    <= '0;
      qr_q     <= '0;
      saw_q    <= '0;
      qw_q     <= '0;
      mode_q   <= M_EXC;
      hdr_idx  <= '0;
      hdr_last <= '0;
      nregs    <= '0;
      reg_cnt  <= '0;
      data_q   <= '0;
      crc      <= 16'hFFFF;
      gap_cnt  <= '0;
      hr_raddr <= '0;
    end else begin
      case (state)
        S_IDLE: if (trig) begin
          ex_q   <= ex_send;
          func_q <= func_code;
          ec_q   <= ex_code;
          sar_q  <= start_addr_r;
          qr_q   <= quantity_r;
          saw_q  <= start_addr_w;
          qw_q   <= quantity_w;
          crc    <= 16'hFFFF;
        end
        S_CHECK: begin
          mode_q   <= chk_mode;
          ec_q     <= chk_ec;
          hdr_idx  <= '0;
          reg_cnt  <= '0;
          hr_raddr <= (chk_mode == M_WR1) ? saw_q[HR_ADDR_W-1:0] : sar_q[HR_ADDR_W-1:0];
          case (chk_mode)
            M_READ:  begin nregs <= qr_q[7:0]; hdr_last <= 3'd2; end
            M_WR1:   begin nregs <= 8'd1;      hdr_last <= 3'd3; end
            M_WRN:   begin nregs <= 8'd0;      hdr_last <= 3'd5; end
            default: begin nregs <= 8'd0;      hdr_last <= 3'd2; end
          endcase
        end
        S_HDR: if (xfer) begin
          hdr_idx <= hdr_idx + 3'd1;
          crc     <= crc_byte(crc, tx_d);
        end
        S_RWAIT: data_q <= bus.hr_rdata;
        S_DHI:   if (xfer) crc <= crc_byte(crc, tx_d);
        S_DLO: if (xfer) begin
          crc      <= crc_byte(crc, tx_d);
          reg_cnt  <= reg_cnt + 8'd1;
          hr_raddr <= hr_raddr + HR_ADDR_W'(1);
        end
        S_CRCHI: if (xfer) gap_cnt <= '0;
        S_GAP:   gap_cnt <= gap_cnt + GAP_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (trig) nstate = S_CHECK;
      S_CHECK: nstate = S_HDR;
      S_HDR:   if (xfer && hdr_idx == hdr_last) nstate = (nregs != 8'd0) ? S_RD : S_CRCLO;
      S_RD:    nstate = S_RWAIT;
      S_RWAIT: nstate = S_DHI;
      S_DHI:   if (xfer) nstate = S_DLO;
      S_DLO:   if (xfer) nstate = (reg_cnt + 8'd1 == nregs) ? S_CRCLO : S_RD;
      S_CRCLO: if (xfer) nstate = S_CRCHI;
      S_CRCHI: if (xfer) nstate = S_GAP;
      S_GAP:   if (gap_cnt == GAP_LAST) nstate = S_DONE;
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      3'd0: hdr_byte = SLAVE_ADDR;
      3'd1: hdr_byte = (mode_q == M_EXC) ? (func_q | 8'h80) : func_q;
      3'd2: hdr_byte = (mode_q == M_EXC)  ? ec_q :
                       (mode_q == M_READ) ? {qr_q[6:0], 1'b0} : saw_q[15:8];
      3'd3: hdr_byte = saw_q[7:0];
      3'd4: hdr_byte = qw_q[15:8];
      3'd5: hdr_byte = qw_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    tx_v  = 1'b0;
    tx_d  = 8'h00;
    hr_rd = 1'b0;
    busy  = (state != S_IDLE);
    done  = 1'b0;
    case (state)
      S_HDR:   begin tx_v = 1'b1; tx_d = hdr_byte;     end
      S_RD:    hr_rd = 1'b1;
      S_DHI:   begin tx_v = 1'b1; tx_d = data_q[15:8]; end
      S_DLO:   begin tx_v = 1'b1; tx_d = data_q[7:0];  end
      S_CRCLO: begin tx_v = 1'b1; tx_d = crc[7:0];     end
      S_CRCHI: begin tx_v = 1'b1; tx_d = crc[15:8];    end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign bus.tx_v     = tx_v;
  assign bus.tx_d     = tx_d;
  assign bus.hr_rd    = hr_rd;
  assign bus.hr_raddr = hr_raddr;
endmodule

// File: tb/tb_modbus_tx.sv
// Directed bench for modbus_tx: table of request vectors with hand-derived frames,
// plus a mid-frame reset sequence.
module tb_modbus_tx;
  localparam int PRESCALER = 4;
  localparam int GAP_CLKS  = 35 * PRESCALER;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        resp_send = 1'b0, ex_send = 1'b0;
  logic [7:0]  func_code = '0, ex_code = '0;
  logic [15:0] start_addr_r = '0, quantity_r = '0, start_addr_w = '0, quantity_w = '0;
  logic        busy, done;

  modbus_tx_if #(.HR_ADDR_W(8)) bus ();

  modbus_tx #(
    .SLAVE_ADDR(8'h01), .PRESCALER(PRESCALER), .HR_ADDR_W(8), .MAX_READ_REGS(125)
  ) dut (
    .clk(clk), .rst(rst), .resp_send(resp_send), .ex_send(ex_send),
    .func_code(func_code), .ex_code(ex_code),
    .start_addr_r(start_addr_r), .quantity_r(quantity_r),
    .start_addr_w(start_addr_w), .quantity_w(quantity_w),
    .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Holding-register RAM: data valid one clk after hr_rd.
  logic [15:0] ram [256];
  always @(posedge clk) if (bus.hr_rd) bus.hr_rdata <= ram[bus.hr_raddr];

  int rdy_pct = 100;
  initial begin
    bus.tx_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.tx_rdy = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Monitor samples at the falling edge, half a period away from the active edge.
  logic [7:0] bytes[$];
  logic [7:0] rd_addrs[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_xfer_cyc = 0, stall_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = '0;
  always @(negedge clk) begin
    cyc++;
    if (!rst) prev_stall = 1'b0;
    else begin
      if (prev_stall && (!bus.tx_v || bus.tx_d != prev_d)) stall_err++;
      prev_stall = bus.tx_v && !bus.tx_rdy;
      prev_d     = bus.tx_d;
      if (bus.tx_v && bus.tx_rdy) begin bytes.push_back(bus.tx_d); last_xfer_cyc = cyc; end
      if (bus.hr_rd) rd_addrs.push_back(bus.hr_raddr);
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  int n_vec = 0, n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bit-serial CRC-16/Modbus reference.
  function automatic logic [15:0] crc_model(input logic [7:0] b[$]);
    logic [15:0] c = 16'hFFFF;
    logic        fb;
    foreach (b[i])
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    return c;
  endfunction

  typedef struct {
    logic        resp, ex;
    logic [7:0]  fc, ec;
    logic [15:0] sar, qr, saw, qw;
    int          rdy_pct;
    bit          hold;
    int          rd_n;
    logic [7:0]  rd_base;
    bit          has_crc;
    logic [15:0] crc;
    int          nb;
    logic [71:0] pl;   // payload bytes, first byte in the top octet
  } vec_t;

  vec_t vecs[12];

  task automatic run_frame(input vec_t v, input int k);
    logic [7:0]  exp_b[$];
    logic [15:0] c;
    int          n;
    bytes.delete(); rd_addrs.delete();
    done_cnt = 0; stall_err = 0; done_cyc = 0; last_xfer_cyc = 0;
    rdy_pct = v.rdy_pct;
    @(negedge clk);
    resp_send = v.resp; ex_send = v.ex; func_code = v.fc; ex_code = v.ec;
    start_addr_r = v.sar; quantity_r = v.qr; start_addr_w = v.saw; quantity_w = v.qw;
    @(negedge clk);
    check($sformatf("v%0d.busy_after_trigger", k), busy, 1);
    check($sformatf("v%0d.tx_v_after_1clk", k), bus.tx_v, 0);
    if (!v.hold) begin resp_send = 0; ex_send = 0; end
    func_code = 8'h5C; ex_code = 8'hEE; start_addr_r = 16'h0042; quantity_r = 16'h0007;
    start_addr_w = 16'h0033; quantity_w = 16'h0009;
    @(negedge clk);
    check($sformatf("v%0d.tx_v_after_2clk", k), bus.tx_v, 1);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
    resp_send = 0; ex_send = 0;
    repeat (4) @(negedge clk);
    check($sformatf("v%0d.done_pulses", k), done_cnt, 1);
    check($sformatf("v%0d.busy_after_done", k), busy, 0);
    check($sformatf("v%0d.gap_clks", k), done_cyc - last_xfer_cyc, GAP_CLKS + 1);
    check($sformatf("v%0d.stall_violations", k), stall_err, 0);
    for (int i = 0; i < v.nb; i++) exp_b.push_back(v.pl[71 - 8*i -: 8]);
    c = v.has_crc ? v.crc : crc_model(exp_b);
    exp_b.push_back(c[7:0]);
    exp_b.push_back(c[15:8]);
    check($sformatf("v%0d.byte_count", k), bytes.size(), exp_b.size());
    n = (bytes.size() < exp_b.size()) ? bytes.size() : exp_b.size();
    for (int i = 0; i < n; i++) check($sformatf("v%0d.byte%0d", k, i), bytes[i], exp_b[i]);
    check($sformatf("v%0d.rd_count", k), rd_addrs.size(), v.rd_n);
    for (int i = 0; i < rd_addrs.size() && i < v.rd_n; i++)
      check($sformatf("v%0d.rd_addr%0d", k, i), rd_addrs[i], 8'(v.rd_base + 8'(i)));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    ram[0] = 16'h0001; ram[1] = 16'h1234; ram[2] = 16'hABCD; ram[3] = 16'h00FF;
    ram[4] = 16'h8001; ram[255] = 16'hBEEF;

    //          resp ex    fc     ec     sar       qr        saw       qw        rdy hold rd base   crc? crc        nb payload
    vecs[0]  = '{1'b1,1'b0,8'h03,8'h00,16'h0000,16'h0001,16'h0000,16'h0000,100,1'b0,1,8'h00,1'b1,16'h8479,5,{8'h01,8'h03,8'h02,8'h00,8'h01,32'h0}};
    vecs[1]  = '{1'b1,1'b0,8'h06,8'h00,16'h0000,16'h0000,16'h0000,16'h0000,100,1'b0,1,8'h00,1'b1,16'h0A48,6,{8'h01,8'h06,8'h00,8'h00,8'h00,8'h01,24'h0}};
    vecs[2]  = '{1'b1,1'b0,8'h03,8'h00,16'h0000,16'h0000,16'h0000,16'h0000,100,1'b0,0,8'h00,1'b0,16'h0000,3,{8'h01,8'h83,8'h03,48'h0}};
    vecs[3]  = '{1'b1,1'b1,8'h03,8'h04,16'h0000,16'h0001,16'h0000,16'h0000,100,1'b0,0,8'h00,1'b0,16'h0000,3,{8'h01,8'h83,8'h04,48'h0}};
    vecs[4]  = '{1'b1,1'b0,8'h10,8'h00,16'h0000,16'h0000,16'h0100,16'h0002,100,1'b0,0,8'h00,1'b0,16'h0000,6,{8'h01,8'h10,8'h01,8'h00,8'h00,8'h02,24'h0}};
    vecs[5]  = '{1'b1,1'b0,8'h07,8'h00,16'h0000,16'h0001,16'h0000,16'h0000,100,1'b0,0,8'h00,1'b0,16'h0000,3,{8'h01,8'h87,8'h01,48'h0}};
    vecs[6]  = '{1'b1,1'b0,8'h03,8'h00,16'h00FF,16'h0001,16'h0000,16'h0000,100,1'b0,1,8'hFF,1'b0,16'h0000,5,{8'h01,8'h03,8'h02,8'hBE,8'hEF,32'h0}};
    vecs[7]  = '{1'b1,1'b0,8'h03,8'h00,16'h00FF,16'h0002,16'h0000,16'h0000,100,1'b0,0,8'h00,1'b0,16'h0000,3,{8'h01,8'h83,8'h02,48'h0}};
    vecs[8]  = '{1'b1,1'b0,8'h17,8'h00,16'h0000,16'h007E,16'h0000,16'h0000,100,1'b0,0,8'h00,1'b0,16'h0000,3,{8'h01,8'h97,8'h03,48'h0}};
    vecs[9]  = '{1'b1,1'b0,8'h17,8'h00,16'h0001,16'h0003,16'h0000,16'h0000, 30,1'b0,3,8'h01,1'b0,16'h0000,9,{8'h01,8'h17,8'h06,8'h12,8'h34,8'hAB,8'hCD,8'h00,8'hFF}};
    vecs[10] = '{1'b1,1'b0,8'h03,8'h00,16'hFFFF,16'h0001,16'h0000,16'h0000,100,1'b0,0,8'h00,1'b0,16'h0000,3,{8'h01,8'h83,8'h02,48'h0}};
    vecs[11] = '{1'b1,1'b0,8'h06,8'h00,16'h0000,16'h0000,16'h0004,16'h0000, 60,1'b1,1,8'h04,1'b0,16'h0000,6,{8'h01,8'h06,8'h00,8'h04,8'h80,8'h01,24'h0}};

    repeat (3) @(negedge clk);
    check("reset.tx_v", bus.tx_v, 0);
    check("reset.tx_d", bus.tx_d, 0);
    check("reset.hr_rd", bus.hr_rd, 0);
    check("reset.hr_raddr", bus.hr_raddr, 0);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    rst = 1'b1;

    for (int k = 0; k < 12; k++) run_frame(vecs[k], k);

    // Abort a Q=4 read in the middle of its data bytes.
    bytes.delete(); done_cnt = 0; rdy_pct = 100;
    @(negedge clk);
    resp_send = 1; func_code = 8'h03; start_addr_r = 16'h0000; quantity_r = 16'h0004;
    @(negedge clk);
    resp_send = 0;
    for (int i = 0; i < 100 && bytes.size() < 5; i++) @(negedge clk);
    check("abort.reached_data", bytes.size() >= 5, 1);
    rst = 1'b0;
    @(negedge clk);
    check("abort.tx_v", bus.tx_v, 0);
    check("abort.busy", busy, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("abort.no_done", done_cnt, 0);
    check("abort.idle_tx_v", bus.tx_v, 0);
    run_frame(vecs[0], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
